// File: rtl/idex_buffer.sv
// ID/EX pipeline register: registers decode's bundle for execute, replays
// push/pop-PC instructions for a second cycle and inserts bubbles on flush.
module idex_buffer #(
    parameter int CTRL_W = 26
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_hold,
    input  logic              i_flush,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_push_pc,
    input  logic              i_pop_pc,
    input  logic [15:0]       i_data1,
    input  logic [15:0]       i_data2,
    input  logic [15:0]       i_immediate,
    input  logic [15:0]       i_sh_amount,
    input  logic [2:0]        i_rd,
    input  logic [2:0]        i_rs,
    input  logic [2:0]        i_write_addr,
    input  logic [31:0]       i_pc,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_push_pc,
    output logic              o_pop_pc,
    output logic [15:0]       o_data1,
    output logic [15:0]       o_data2,
    output logic [15:0]       o_immediate,
    output logic [15:0]       o_sh_amount,
    output logic [2:0]        o_rd,
    output logic [2:0]        o_rs,
    output logic [2:0]        o_write_addr,
    output logic [31:0]       o_pc,
    output logic              o_hazard_state,
    output logic              o_stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              push_pc;
        logic              pop_pc;
        logic [15:0]       data1;
        logic [15:0]       data2;
        logic [15:0]       immediate;
        logic [15:0]       sh_amount;
        logic [2:0]        rd;
        logic [2:0]        rs;
        logic [2:0]        write_addr;
        logic [31:0]       pc;
    } bundle_t;

    state_t  state_q, state_d;
    bundle_t bundle_q, bundle_d;
    bundle_t bundle_in;

    assign bundle_in = '{
        ctrl:       i_ctrl,
        push_pc:    i_push_pc,
        pop_pc:     i_pop_pc,
        data1:      i_data1,
        data2:      i_data2,
        immediate:  i_immediate,
        sh_amount:  i_sh_amount,
        rd:         i_rd,
        rs:         i_rs,
        write_addr: i_write_addr,
        pc:         i_pc
    };

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latches.
        state_d  = state_q;
        bundle_d = bundle_q;
        if (i_hold) begin
            state_d  = state_q;
        end else if (state_q == FIRST) begin
            // The held push/pop instruction always completes; flush waits.
            state_d  = SECOND;
        end else if (i_flush) begin
            bundle_d = '0;
            state_d  = IDLE;
        end else begin
            bundle_d = bundle_in;
            state_d  = (i_push_pc || i_pop_pc) ? FIRST : IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            bundle_q <= bundle_d;
        end
    end

    assign o_ctrl         = bundle_q.ctrl;
    assign o_push_pc      = bundle_q.push_pc;
    assign o_pop_pc       = bundle_q.pop_pc;
    assign o_data1        = bundle_q.data1;
    assign o_data2        = bundle_q.data2;
    assign o_immediate    = bundle_q.immediate;
    assign o_sh_amount    = bundle_q.sh_amount;
    assign o_rd           = bundle_q.rd;
    assign o_rs           = bundle_q.rs;
    assign o_write_addr   = bundle_q.write_addr;
    assign o_pc           = bundle_q.pc;
    assign o_hazard_state = (state_q == SECOND);
    assign o_stall        = (state_q == FIRST);

endmodule
